// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer for the 4-bit CPU: drives memory requests, IR/PC strobes and execute-cycle controls.
// Optional build macro SINGLE_STEP_EN adds a step input and a PAUSE state after every executed instruction.
module control_sequencer #(
    parameter int unsigned FETCH_TIMEOUT = 15,
    parameter int unsigned CNT_W         = 4
) (
    input  logic       clk,
    input  logic       reset,
`ifdef SINGLE_STEP_EN
    input  logic       step,
`endif
    input  logic       mem_ack,
    input  logic [3:0] op_code,
    input  logic       zero_flag,
    output logic       mem_req,
    output logic       ir_load_en,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       reg_we,
    output logic       imm_sel,
    output logic       alu_en,
    output logic [2:0] alu_op,
    output logic       halted,
    output logic       fault,
    output logic       illegal_op
);

`ifdef SINGLE_STEP_EN
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT, S_FAULT, S_PAUSE
    } state_t;
    localparam state_t AFTER_EXEC = S_PAUSE;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT, S_FAULT
    } state_t;
    localparam state_t AFTER_EXEC = S_FETCH;
`endif

    localparam bit              TIMEOUT_EN = (FETCH_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((FETCH_TIMEOUT == 0) ? 0 : FETCH_TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             illegal_q;

    function automatic logic op_defined(input logic [3:0] op);
        return (op <= 4'h9) || (op == 4'hF);
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    // An ack on the final allowed wait cycle still completes the fetch.
                    if (mem_ack) begin
                        state    <= S_DECODE;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                        if (TIMEOUT_EN && (wait_cnt == LAST_WAIT))
                            state <= S_FAULT;
                    end
                end
                S_DECODE: begin
                    if (op_code == 4'hF) begin
                        state <= S_HALT;
                    end else if (!op_defined(op_code)) begin
                        illegal_q <= 1'b1;
                        state     <= AFTER_EXEC;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: state <= AFTER_EXEC;
`ifdef SINGLE_STEP_EN
                S_PAUSE: if (step) state <= S_FETCH;
`endif
                S_HALT, S_FAULT: state <= state;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        ir_load_en = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        reg_we     = 1'b0;
        imm_sel    = 1'b0;
        alu_en     = 1'b0;
        alu_op     = 3'd0;
        halted     = 1'b0;
        fault      = 1'b0;
        illegal_op = reset & illegal_q;
        if (reset) begin
            case (state)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    ir_load_en = mem_ack;
                    pc_inc     = mem_ack;
                end
                S_EXEC: begin
                    case (op_code)
                        4'h1: begin
                            reg_we  = 1'b1;
                            imm_sel = 1'b1;
                        end
                        4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                            // MOV..XOR map onto PASS..XOR in opcode order.
                            alu_en = 1'b1;
                            reg_we = 1'b1;
                            alu_op = 3'(op_code - 4'd2);
                        end
                        4'h8:    pc_load = 1'b1;
                        4'h9:    pc_load = zero_flag;
                        default: ;
                    endcase
                end
                S_HALT:  halted = 1'b1;
                S_FAULT: fault  = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus a randomized instruction stream
// checked cycle by cycle against a per-instruction timing/strobe model.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       mem_ack = 1'b0;
    logic [3:0] op_code = 4'h0;
    logic       zero_flag = 1'b0;
    logic       step = 1'b0;
    logic       mem_req, ir_load_en, pc_inc, pc_load, reg_we, imm_sel, alu_en;
    logic [2:0] alu_op;
    logic       halted, fault, illegal_op;

    int checks = 0;
    int errors = 0;

    localparam logic [12:0] M_REQ = 13'h1000;
    localparam logic [12:0] IRL   = 13'h0800;
    localparam logic [12:0] PCI   = 13'h0400;
    localparam logic [12:0] PCL   = 13'h0200;
    localparam logic [12:0] WE    = 13'h0100;
    localparam logic [12:0] IMM   = 13'h0080;
    localparam logic [12:0] ALU   = 13'h0040;
    localparam logic [12:0] HLT   = 13'h0004;
    localparam logic [12:0] FLT   = 13'h0002;
    localparam logic [12:0] ILL   = 13'h0001;
    localparam logic [12:0] FETCH_OK = M_REQ | IRL | PCI;

    always #5 clk = ~clk;

    control_sequencer #(.FETCH_TIMEOUT(15), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef SINGLE_STEP_EN
        .step       (step),
`endif
        .mem_ack    (mem_ack),
        .op_code    (op_code),
        .zero_flag  (zero_flag),
        .mem_req    (mem_req),
        .ir_load_en (ir_load_en),
        .pc_inc     (pc_inc),
        .pc_load    (pc_load),
        .reg_we     (reg_we),
        .imm_sel    (imm_sel),
        .alu_en     (alu_en),
        .alu_op     (alu_op),
        .halted     (halted),
        .fault      (fault),
        .illegal_op (illegal_op)
    );

    // Expected execute-cycle strobes, straight from the opcode table.
    function automatic logic [12:0] exec_vec(input logic [3:0] op, input logic zf);
        logic [12:0] v;
        v = '0;
        case (op)
            4'h1: v = WE | IMM;
            4'h2: begin v = ALU | WE; v[5:3] = 3'd0; end
            4'h3: begin v = ALU | WE; v[5:3] = 3'd1; end
            4'h4: begin v = ALU | WE; v[5:3] = 3'd2; end
            4'h5: begin v = ALU | WE; v[5:3] = 3'd3; end
            4'h6: begin v = ALU | WE; v[5:3] = 3'd4; end
            4'h7: begin v = ALU | WE; v[5:3] = 3'd5; end
            4'h8: v = PCL;
            4'h9: v = zf ? PCL : 13'h0;
            default: v = '0;
        endcase
        return v;
    endfunction

    // One clock cycle: drive inputs just after the rising edge, sample outputs on the falling edge.
    task automatic tick(input logic ack, input logic [3:0] op, input logic zf, input logic stp,
                        output logic [12:0] obs);
        mem_ack   = ack;
        op_code   = op;
        zero_flag = zf;
        step      = stp;
        @(negedge clk);
        obs = {mem_req, ir_load_en, pc_inc, pc_load, reg_we, imm_sel, alu_en, alu_op,
               halted, fault, illegal_op};
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        logic [12:0] obs;
        reset = 1'b0;
        tick(1'($urandom), 4'($urandom), 1'b0, 1'b0, obs);
        tick(1'($urandom), 4'($urandom), 1'b0, 1'b0, obs);
        reset = 1'b1;
        tick(1'b0, 4'h0, 1'b0, 1'b0, obs);
    endtask

    task automatic test_reset();
        logic [12:0] obs;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 4'h3, 1'b1, 1'b1, obs);
            checks++; if (obs !== 13'h0) begin errors++; $display("FAIL reset_por: got %h expected %h", obs, 13'h0); end
        end
        reset = 1'b1;
        tick(1'b0, 4'h0, 1'b0, 1'b0, obs);
        checks++; if (obs !== 13'h0) begin errors++; $display("FAIL reset_idle: got %h expected %h", obs, 13'h0); end
        tick(1'b1, 4'h0, 1'b0, 1'b0, obs);
        checks++; if (obs !== FETCH_OK) begin errors++; $display("FAIL reset_first_fetch: got %h expected %h", obs, FETCH_OK); end
        tick(1'b1, 4'h3, 1'b0, 1'b0, obs);
        checks++; if (obs !== 13'h0) begin errors++; $display("FAIL reset_decode: got %h expected %h", obs, 13'h0); end
        // Now in EXEC: pull reset for 3 cycles with mem_ack high.
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 4'h3, 1'b0, 1'b1, obs);
            checks++; if (obs !== 13'h0) begin errors++; $display("FAIL reset_mid_exec: got %h expected %h", obs, 13'h0); end
        end
        reset = 1'b1;
        tick(1'b1, 4'h3, 1'b0, 1'b0, obs);
        checks++; if (obs !== 13'h0) begin errors++; $display("FAIL reset_idle2: got %h expected %h", obs, 13'h0); end
        tick(1'b0, 4'h3, 1'b0, 1'b0, obs);
        checks++; if (obs !== M_REQ) begin errors++; $display("FAIL reset_req: got %h expected %h", obs, M_REQ); end
    endtask

    task automatic test_add();
        logic [12:0] obs;
        do_reset();
        tick(1'b1, 4'hC, 1'b0, 1'b0, obs);
        checks++; if (obs !== FETCH_OK) begin errors++; $display("FAIL add_fetch: got %h expected %h", obs, FETCH_OK); end
        tick(1'b1, 4'h3, 1'b0, 1'b0, obs);
        checks++; if (obs !== 13'h0) begin errors++; $display("FAIL add_decode: got %h expected %h", obs, 13'h0); end
        tick(1'b1, 4'h3, 1'b0, 1'b0, obs);
        checks++; if (obs !== (ALU | WE | 13'h0008)) begin errors++; $display("FAIL add_exec: got %h expected %h", obs, ALU | WE | 13'h0008); end
`ifdef SINGLE_STEP_EN
        tick(1'b1, 4'h3, 1'b0, 1'b1, obs);
        checks++; if (obs !== 13'h0) begin errors++; $display("FAIL add_pause: got %h expected %h", obs, 13'h0); end
`endif
        tick(1'b1, 4'h3, 1'b0, 1'b0, obs);
        checks++; if (obs !== FETCH_OK) begin errors++; $display("FAIL add_next_fetch: got %h expected %h", obs, FETCH_OK); end
    endtask

    task automatic test_jz();
        logic [12:0] obs;
        do_reset();
        for (int z = 0; z < 2; z++) begin
            tick(1'b1, 4'h0, 1'(z), 1'b0, obs);
            checks++; if (obs !== FETCH_OK) begin errors++; $display("FAIL jz_fetch: got %h expected %h", obs, FETCH_OK); end
            tick(1'b0, 4'h9, 1'(z), 1'b0, obs);
            checks++; if (obs !== 13'h0) begin errors++; $display("FAIL jz_decode: got %h expected %h", obs, 13'h0); end
            tick(1'b0, 4'h9, 1'(z), 1'b0, obs);
            checks++; if (obs !== ((z != 0) ? PCL : 13'h0)) begin errors++; $display("FAIL jz_exec_z%0d: got %h expected %h", z, obs, (z != 0) ? PCL : 13'h0); end
`ifdef SINGLE_STEP_EN
            tick(1'b0, 4'h9, 1'(z), 1'b1, obs);
            checks++; if (obs !== 13'h0) begin errors++; $display("FAIL jz_pause: got %h expected %h", obs, 13'h0); end
`endif
        end
        tick(1'b0, 4'h9, 1'b1, 1'b0, obs);
        checks++; if (obs !== M_REQ) begin errors++; $display("FAIL jz_after: got %h expected %h", obs, M_REQ); end
    endtask

    task automatic test_timeout();
        logic [12:0] obs;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            tick(1'b0, 4'h0, 1'b0, 1'b1, obs);
            checks++; if (obs !== M_REQ) begin errors++; $display("FAIL to_wait%0d: got %h expected %h", i, obs, M_REQ); end
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 4'h1, 1'b0, 1'b1, obs);
            checks++; if (obs !== FLT) begin errors++; $display("FAIL to_fault: got %h expected %h", obs, FLT); end
        end
        do_reset();
        for (int i = 0; i < 14; i++) begin
            tick(1'b0, 4'h0, 1'b0, 1'b0, obs);
            checks++; if (obs !== M_REQ) begin errors++; $display("FAIL to_wait_b%0d: got %h expected %h", i, obs, M_REQ); end
        end
        tick(1'b1, 4'h0, 1'b0, 1'b0, obs);
        checks++; if (obs !== FETCH_OK) begin errors++; $display("FAIL to_late_ack: got %h expected %h", obs, FETCH_OK); end
        tick(1'b0, 4'h1, 1'b0, 1'b0, obs);
        checks++; if (obs !== 13'h0) begin errors++; $display("FAIL to_late_decode: got %h expected %h", obs, 13'h0); end
        tick(1'b0, 4'h1, 1'b0, 1'b0, obs);
        checks++; if (obs !== (WE | IMM)) begin errors++; $display("FAIL to_late_exec: got %h expected %h", obs, WE | IMM); end
    endtask

    task automatic test_illegal_halt();
        logic [12:0] obs;
        do_reset();
        tick(1'b1, 4'h0, 1'b0, 1'b0, obs);
        checks++; if (obs !== FETCH_OK) begin errors++; $display("FAIL ill_fetch: got %h expected %h", obs, FETCH_OK); end
        tick(1'b1, 4'hA, 1'b0, 1'b0, obs);
        checks++; if (obs !== 13'h0) begin errors++; $display("FAIL ill_decode: got %h expected %h", obs, 13'h0); end
`ifdef SINGLE_STEP_EN
        tick(1'b1, 4'hA, 1'b0, 1'b1, obs);
        checks++; if (obs !== ILL) begin errors++; $display("FAIL ill_pause: got %h expected %h", obs, ILL); end
`endif
        tick(1'b1, 4'hA, 1'b0, 1'b0, obs);
        checks++; if (obs !== (FETCH_OK | ILL)) begin errors++; $display("FAIL ill_refetch: got %h expected %h", obs, FETCH_OK | ILL); end
        tick(1'b1, 4'hF, 1'b0, 1'b1, obs);
        checks++; if (obs !== ILL) begin errors++; $display("FAIL halt_decode: got %h expected %h", obs, ILL); end
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 4'hF, 1'b1, 1'b1, obs);
            checks++; if (obs !== (HLT | ILL)) begin errors++; $display("FAIL halt_hold: got %h expected %h", obs, HLT | ILL); end
        end
        do_reset();
        tick(1'b0, 4'h0, 1'b0, 1'b0, obs);
        checks++; if (obs !== M_REQ) begin errors++; $display("FAIL ill_cleared: got %h expected %h", obs, M_REQ); end
    endtask

`ifdef SINGLE_STEP_EN
    task automatic test_single_step();
        logic [12:0] obs;
        do_reset();
        tick(1'b1, 4'h0, 1'b0, 1'b1, obs);
        checks++; if (obs !== FETCH_OK) begin errors++; $display("FAIL ss_fetch: got %h expected %h", obs, FETCH_OK); end
        tick(1'b1, 4'h1, 1'b0, 1'b1, obs);
        checks++; if (obs !== 13'h0) begin errors++; $display("FAIL ss_decode: got %h expected %h", obs, 13'h0); end
        tick(1'b1, 4'h1, 1'b0, 1'b1, obs);
        checks++; if (obs !== (WE | IMM)) begin errors++; $display("FAIL ss_exec: got %h expected %h", obs, WE | IMM); end
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 4'h1, 1'b0, 1'b0, obs);
            checks++; if (obs !== 13'h0) begin errors++; $display("FAIL ss_hold: got %h expected %h", obs, 13'h0); end
        end
        tick(1'b1, 4'h1, 1'b0, 1'b1, obs);
        checks++; if (obs !== 13'h0) begin errors++; $display("FAIL ss_step: got %h expected %h", obs, 13'h0); end
        tick(1'b1, 4'h1, 1'b0, 1'b0, obs);
        checks++; if (obs !== FETCH_OK) begin errors++; $display("FAIL ss_resume: got %h expected %h", obs, FETCH_OK); end
    endtask
`endif

    // Random instruction stream: each instruction contributes waits, an ack cycle, a decode cycle,
    // an execute cycle for defined opcodes, and (single-step builds) a pause until step.
    task automatic test_random();
        logic [12:0] obs;
        logic [12:0] exp;
        logic [12:0] ill;
        logic [3:0]  op;
        logic        zf;
        int          waits;
        do_reset();
        ill = '0;
        for (int n = 0; n < 60; n++) begin
            waits = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 14)) : int'($urandom_range(0, 2));
            op    = 4'($urandom_range(0, 14));
            zf    = 1'($urandom);
            for (int w = 0; w < waits; w++) begin
                tick(1'b0, 4'($urandom), 1'($urandom), 1'($urandom), obs);
                exp = M_REQ | ill;
                checks++; if (obs !== exp) begin errors++; $display("FAIL rnd_wait n%0d: got %h expected %h", n, obs, exp); end
            end
            tick(1'b1, 4'($urandom), 1'($urandom), 1'($urandom), obs);
            exp = FETCH_OK | ill;
            checks++; if (obs !== exp) begin errors++; $display("FAIL rnd_ack n%0d: got %h expected %h", n, obs, exp); end
            tick(1'($urandom), op, zf, 1'($urandom), obs);
            checks++; if (obs !== ill) begin errors++; $display("FAIL rnd_decode n%0d op%h: got %h expected %h", n, op, obs, ill); end
            if (op > 4'h9) begin
                ill = ILL;
            end else begin
                tick(1'($urandom), op, zf, 1'($urandom), obs);
                exp = exec_vec(op, zf) | ill;
                checks++; if (obs !== exp) begin errors++; $display("FAIL rnd_exec n%0d op%h: got %h expected %h", n, op, obs, exp); end
            end
`ifdef SINGLE_STEP_EN
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                tick(1'($urandom), op, 1'($urandom), 1'b0, obs);
                checks++; if (obs !== ill) begin errors++; $display("FAIL rnd_pause n%0d: got %h expected %h", n, obs, ill); end
            end
            tick(1'($urandom), op, 1'($urandom), 1'b1, obs);
            checks++; if (obs !== ill) begin errors++; $display("FAIL rnd_step n%0d: got %h expected %h", n, obs, ill); end
`endif
        end
        tick(1'b1, 4'h0, 1'b0, 1'b0, obs);
        exp = FETCH_OK | ill;
        checks++; if (obs !== exp) begin errors++; $display("FAIL rnd_final_fetch: got %h expected %h", obs, exp); end
        tick(1'b0, 4'hF, 1'b0, 1'b0, obs);
        tick(1'b1, 4'hF, 1'b0, 1'b1, obs);
        exp = HLT | ill;
        checks++; if (obs !== exp) begin errors++; $display("FAIL rnd_halt: got %h expected %h", obs, exp); end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_jz();
        test_timeout();
        test_illegal_halt();
`ifdef SINGLE_STEP_EN
        test_single_step();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
